// File: rtl/div_core_pkg.sv
// Shared definitions for the EX-stage divider: state encodings, handshake
// levels and bus widths.
package div_core_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 2 * RegBus;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_core.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock.
// Result is packed {remainder, quotient} so EX writes HI/LO directly.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// DivFree   | idle; accepts start_i and latches operands
// DivByZero | divisor was zero; one bubble before presenting a zero result
// DivOn     | iterating; one quotient bit per cycle, WIDTH cycles total
// DivEnd    | result presented with ready_o high until start_i drops
module div_core
  import div_core_pkg::*;
#(
  parameter int WIDTH = RegBus
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  div_state_e state, state_n;

  // work holds the unconsumed dividend bits at the top and the quotient
  // bits shifted in at the bottom; after WIDTH steps it is the quotient.
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic             neg_quo;
  logic             neg_rem;

  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] work_nxt;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             stop;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= DivFree;
    else     state <= state_n;
  end

  // Next-state decode; annul wins over start, a dropped start aborts.
  always_comb begin
    state_n = state;
    stop    = annul_i || (start_i == DivStop);
    case (state)
      DivFree: begin
        if (start_i == DivStart && !annul_i)
          state_n = (opdata2_i == '0) ? DivByZero : DivOn;
      end
      DivByZero: state_n = stop ? DivFree : DivEnd;
      DivOn: begin
        if (stop)                   state_n = DivFree;
        else if (cnt == LAST_ITER)  state_n = DivEnd;
      end
      DivEnd:  if (stop) state_n = DivFree;
      default: state_n = DivFree;
    endcase
  end

  // One restoring step plus the sign fix-up applied on the last step.
  always_comb begin
    trial    = {rem, work[WIDTH-1]};
    fits     = trial >= {1'b0, divisor};
    // The true difference is below the divisor, so the low WIDTH bits suffice.
    rem_nxt  = fits ? (trial[WIDTH-1:0] - divisor) : trial[WIDTH-1:0];
    work_nxt = {work[WIDTH-2:0], fits};
    quo_fix  = neg_quo ? negate(work_nxt) : work_nxt;
    rem_fix  = neg_rem ? negate(rem_nxt) : rem_nxt;
  end

  // Operand capture, iteration registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      work     <= '0;
      divisor  <= '0;
      rem      <= '0;
      cnt      <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      ready_o  <= DivResultNotReady;
      result_o <= '0;
    end else begin
      if (state == DivFree && state_n != DivFree) begin
        neg_quo <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
        neg_rem <= signed_div_i && opdata1_i[WIDTH-1];
        work    <= (signed_div_i && opdata1_i[WIDTH-1]) ? negate(opdata1_i) : opdata1_i;
        divisor <= (signed_div_i && opdata2_i[WIDTH-1]) ? negate(opdata2_i) : opdata2_i;
        rem     <= '0;
        cnt     <= '0;
      end else if (state == DivOn && state_n != DivFree) begin
        work <= work_nxt;
        rem  <= rem_nxt;
        cnt  <= cnt + 1'b1;
      end

      ready_o <= (state_n == DivEnd) ? DivResultReady : DivResultNotReady;

      if (state == DivOn && state_n == DivEnd)
        result_o <= {rem_fix, quo_fix};
      else if (!(state == DivEnd && state_n == DivEnd))
        result_o <= '0;
    end
  end

endmodule

// File: tb/tb_div_core.sv
// Directed bench for div_core: vector table plus handshake corner sequences.
module tb_div_core;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           start_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;

  int errors = 0;
  int checks = 0;

  div_core #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
    logic         scramble;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts rising edges from the acceptance edge (edge 1) until ready_o.
  task automatic wait_ready(input logic scramble, output int lat);
    lat = 0;
    for (int i = 1; i <= 60 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) lat = i;
      else if (scramble) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end
    end
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic run_div(input vec_t v);
    int lat;
    signed_div_i = v.sgn;
    opdata1_i    = v.a;
    opdata2_i    = v.b;
    start_i      = 1'b1;
    wait_ready(v.scramble, lat);
    chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
    chk({v.name, " result"}, result_o, {v.r, v.q});
    @(posedge clk); #1;
    chk({v.name, " held ready"}, 64'(ready_o), 64'd1);
    chk({v.name, " held result"}, result_o, {v.r, v.q});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({v.name, " drop ready"}, 64'(ready_o), 64'd0);
    chk({v.name, " drop result"}, result_o, 64'd0);
    @(negedge clk);
  endtask

  vec_t vecs[$];
  vec_t v;
  int   lat;
  int   seen;

  initial begin
    vecs.push_back('{"u100/7",    1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        33, 1'b0});
    vecs.push_back('{"s-7/2",     1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 33, 1'b0});
    vecs.push_back('{"s7/-2",     1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        33, 1'b0});
    vecs.push_back('{"u/0",       1'b0, 32'h12345678, 32'd0,        32'd0,        32'd0,        2,  1'b0});
    vecs.push_back('{"s/0",       1'b1, 32'h80000000, 32'd0,        32'd0,        32'd0,        2,  1'b0});
    vecs.push_back('{"smin/-1",   1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        33, 1'b0});
    vecs.push_back('{"umax/1",    1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        33, 1'b0});
    vecs.push_back('{"u5/9",      1'b0, 32'd5,        32'd9,        32'd0,        32'd5,        33, 1'b0});
    vecs.push_back('{"uFFF9/2",   1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1,        33, 1'b0});
    vecs.push_back('{"s-100/-7",  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 33, 1'b0});
    vecs.push_back('{"scr1000/7", 1'b0, 32'd1000,     32'd7,        32'd142,      32'd6,        33, 1'b1});
    vecs.push_back('{"scr-9/4",   1'b1, 32'hFFFFFFF7, 32'd4,        32'hFFFFFFFE, 32'hFFFFFFFF, 33, 1'b1});

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_div(vecs[i]);

    // annul pulsed during iteration 10, then a fresh start the next cycle
    signed_div_i = 1'b0; opdata1_i = 32'd500; opdata2_i = 32'd3; start_i = 1'b1;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (ready_o) seen++; end
    @(negedge clk); annul_i = 1'b1;
    @(posedge clk); #1; if (ready_o) seen++;
    @(negedge clk); annul_i = 1'b0; start_i = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ready_o) seen++; end
    chk("annul no ready", 64'(seen), 64'd0);
    @(negedge clk);
    v = '{"after annul 20/3", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 33, 1'b0};
    run_div(v);

    // annul with start held: FREE next cycle, then restart straight away
    signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); annul_i = 1'b1;
    @(posedge clk); #1;
    chk("annul held ready", 64'(ready_o), 64'd0);
    @(negedge clk); annul_i = 1'b0;
    v = '{"restart 20/3", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 33, 1'b0};
    run_div(v);

    // start dropped in ON aborts silently
    signed_div_i = 1'b0; opdata1_i = 32'd99; opdata2_i = 32'd4; start_i = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); start_i = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (ready_o) seen++; end
    chk("abort no ready", 64'(seen), 64'd0);
    @(negedge clk);

    // annul in END behaves like dropping start
    signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd4; start_i = 1'b1;
    wait_ready(1'b0, lat);
    chk("end-annul latency", 64'(lat), 64'd33);
    chk("end-annul result", result_o, {32'd1, 32'd2});
    @(negedge clk); annul_i = 1'b1;
    @(posedge clk); #1;
    chk("end-annul ready", 64'(ready_o), 64'd0);
    chk("end-annul result0", result_o, 64'd0);
    @(negedge clk); annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // synchronous reset mid-ON, start held: must come back in FREE
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midON rst ready", 64'(ready_o), 64'd0);
    chk("midON rst result", result_o, 64'd0);
    @(negedge clk); rst = 1'b0;
    v = '{"post-rst 20/3", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 33, 1'b0};
    run_div(v);

    // reset while presenting a result clears the outputs
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd8; start_i = 1'b1;
    wait_ready(1'b0, lat);
    chk("end rst latency", 64'(lat), 64'd33);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("end rst ready", 64'(ready_o), 64'd0);
    chk("end rst result", result_o, 64'd0);
    @(negedge clk); rst = 1'b0; start_i = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_core.md
Name: div_core

Overview:
- Multi-cycle 32-bit integer divider. It is the responder side of the EX-stage divide handshake (start, operands, signed flag in; ready and result out).
- Uses a radix-2 restoring algorithm, one quotient bit per cycle.
- Result packing is {remainder, quotient}, so EX writes HI = remainder and LO = quotient directly.
- Sits beside EX and is clocked with the pipeline; EX stalls the pipeline while ready_o is low.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH. The iteration count equals WIDTH.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  reset, synchronous, active-high
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  input  WIDTH  dividend
- opdata2_i  input  WIDTH  divisor
- start_i  input  1  DivStart request, held high by EX until ready_o is seen
- annul_i  input  1  flush (exception/eret); aborts any operation in progress
- result_o  output  2*WIDTH  {remainder, quotient}; valid only while ready_o = 1
- ready_o  output  1  DivResultReady; registered

Behaviour:
- State machine states: FREE, BYZERO, ON, END. Reset state is FREE.
- Reset (rst=1 at a clock edge), including mid-operation:
  - state goes to FREE; ready_o = 0; result_o = 0; counter = 0; working registers = 0.
- FREE:
  - start_i=1 and annul_i=0 in cycle N: latch signed_div_i, opdata1_i and opdata2_i.
  - If divisor = 0 → BYZERO.
  - Otherwise, if signed, convert each negative operand to its two's-complement magnitude, then → ON with counter = 0.
  - Operands are latched only at acceptance; later input changes are ignored.
- BYZERO: one cycle, then → END with result = 0.
- ON: one iteration per cycle.
  - Shift the partial remainder left by one, bringing in the next dividend bit (MSB first).
  - If partial remainder ≥ |divisor|: subtract and shift a 1 into the quotient; else shift in 0.
  - After the WIDTH-th iteration, in cycle N+WIDTH, → END.
- Result fix-up, computed on the transition into END:
  - Signed, operand signs differ: negate the quotient.
  - Signed, dividend negative: negate the remainder.
  - Quotient arithmetic wraps mod 2^WIDTH, so 0x80000000 / -1 yields quotient 0x80000000, remainder 0.
- END:
  - ready_o = 1 and result_o holds the final value.
  - Nonzero divisor: first ready cycle is N+WIDTH+1 (N+33 for WIDTH=32).
  - Divide-by-zero: first ready cycle is N+2.
  - Stay in END while start_i=1.
  - start_i=0 → FREE next cycle, with ready_o = 0 and result_o = 0.
- annul_i=1 in BYZERO or ON → FREE next cycle; ready_o stays 0; no result is produced.
- annul_i=1 in END: same as start_i=0.
- start_i falling in ON or BYZERO without annul: treated as an abort, → FREE.
- Simultaneous events:
  - annul_i has priority over start_i in every state.
  - rst has priority over everything.
- Back-to-back operations: a new start_i is accepted in the first FREE cycle after END. There is no overlap.
- ready_o and result_o are driven only from registers; there is no combinational path from inputs to outputs.

Decomposition:
- Shared defines header holds:
  - state encodings DivFree / DivByZero / DivOn / DivEnd;
  - DivStart / DivStop;
  - DivResultReady / DivResultNotReady;
  - DoubleRegBus and RegBus widths;
  - ZeroWord.
- Single module; no sub-module. The negate/magnitude logic is an inline function.

Test Plan:
- Unsigned 100 / 7, start held until ready:
  - ready_o rises exactly 33 cycles after acceptance;
  - result = {32'd2, 32'd14};
  - start dropped → ready_o = 0 and result_o = 0 next cycle.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero, 0x12345678 / 0 → ready_o at cycle +2, result = 64'h0.
- Corner cases:
  - signed 0x80000000 / 0xFFFFFFFF → {0, 0x80000000};
  - unsigned 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF};
  - unsigned 5 / 9 → {5, 0}.
- annul_i pulsed at iteration 10:
  - ready_o never rises; FREE next cycle;
  - a new start (20 / 3) issued the following cycle completes at +33 with {2, 6}.
- Stability and reset:
  - opdata inputs randomised every cycle during ON → result still matches the operands latched at acceptance;
  - rst asserted mid-ON → FREE, outputs 0 next cycle.
